// File: rtl/lock_entry_pkg.sv
// Shared types and constants for the combination-lock key entry front end.
package lock_entry_pkg;

  // Debounce FSM states for the KEY[0] pushbutton.
  typedef enum logic [1:0] {
    S_ARM   = 2'd0,
    S_IDLE  = 2'd1,
    S_PRESS = 2'd2,
    S_HELD  = 2'd3
  } state_t;

  localparam int DIGIT_W           = 4;
  localparam int MAX_DIGIT_DEFAULT = 9;

  // True when a captured switch value is a legal lock digit.
  function automatic logic digit_ok(input logic [DIGIT_W-1:0] d, input int max_digit);
    return (int'(d) <= max_digit);
  endfunction

endpackage

// File: rtl/lock_key_entry_sync2.sv
// Two-flop synchroniser of parameterised width with a configurable reset value.
module sync2 #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops give the first stage a full cycle to settle out of metastability.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lock_key_entry.sv
// Debounces KEY[0] and emits one enter strobe per press with the SW[3:0] digit captured.
module lock_key_entry
  import lock_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MAX_DIGIT       = MAX_DIGIT_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               key_n,
  input  logic [DIGIT_W-1:0] sw,
  output logic               enter_pulse,
  output logic [DIGIT_W-1:0] digit_out,
  output logic               digit_valid,
  output logic               key_held
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic               key_s;
  logic [DIGIT_W-1:0] sw_s;
  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               capture;

  // The key idles high so its synchroniser resets to "released".
  sync2 #(
    .WIDTH       (1),
    .RESET_VALUE (1'b1)
  ) u_sync_key (
    .clock (clock),
    .reset (reset),
    .d     (key_n),
    .q     (key_s)
  );

  sync2 #(
    .WIDTH       (DIGIT_W),
    .RESET_VALUE ('0)
  ) u_sync_sw (
    .clock (clock),
    .reset (reset),
    .d     (sw),
    .q     (sw_s)
  );

  // Debounce sequencing: a press or a release must be stable for DEBOUNCE_CYCLES samples.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      S_ARM: begin
        if (!key_s) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_IDLE: begin
        if (!key_s) begin
          state_nxt = S_PRESS;
          cnt_nxt   = CNT_ONE;
        end
      end
      S_PRESS: begin
        if (key_s) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_HELD;
          cnt_nxt   = '0;
          capture   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_HELD: begin
        if (key_s) begin
          state_nxt = S_ARM;
          cnt_nxt   = CNT_ONE;
        end
      end
      default: begin
        state_nxt = S_ARM;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and counter registers; reset forces a fresh release debounce before any press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_ARM;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Strobe and digit capture happen only on the edge that accepts a press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enter_pulse <= 1'b0;
      digit_out   <= '0;
      digit_valid <= 1'b1;
    end else begin
      enter_pulse <= capture;
      if (capture) begin
        digit_out   <= sw_s;
        digit_valid <= digit_ok(sw_s, MAX_DIGIT);
      end
    end
  end

  assign key_held = (state == S_HELD);

endmodule
